arith_pipe: RTL and testbench

ARITH_PIPE -- requirements
Module: arith_pipe

---
 rtl/arith_pipe_pkg.sv | 12 +
 rtl/arith_pipe_pipe_stage.sv | 45 ++++
 rtl/arith_pipe.sv | 119 +++++++++++
 tb/tb_arith_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pipe_pkg.sv
// Shared definitions for the arith_pipe block.
//   DEFAULT_WIDTH : default operand/result width in bits
//   MODE_MULSUM   : mode encoding for f = (a+b+c-d)*d with overflow flag
//   MODE_SUM      : mode encoding for f = a+b+c-d, ovf forced to 0
package arith_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam int unsigned MODE_MULSUM = 0;
  localparam int unsigned MODE_SUM    = 1;

endpackage

// File: rtl/arith_pipe_pipe_stage.sv
// Generic pipeline register: one valid bit plus a data word.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset, clears valid and data
//   hold      : keep current contents (downstream stall)
//   clear     : drop valid at the next edge; takes priority over hold
//   in_valid  : upstream stage holds a transaction
//   in_data   : upstream payload
//   out_valid : this stage holds a transaction
//   out_data  : registered payload
module pipe_stage #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [DataW-1:0] in_data,
  output logic             out_valid,
  output logic [DataW-1:0] out_data
);

  logic             valid_q;
  logic [DataW-1:0] data_q;

  // Data only loads alongside a valid transaction, so bubbles never disturb
  // the word a downstream consumer may be looking at.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (!hold) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/arith_pipe.sv
// Three-stage arithmetic pipeline with valid/ready handshakes.
//   S1: y1 = a+b, y2 = c-d (modulo 2^WIDTH), carry d and mode
//   S2: y3 = y1+y2, carry d and mode
//   S3: MULSUM -> f = low WIDTH bits of y3*d, ovf = upper bits nonzero
//       SUM    -> f = y3, ovf = 0
// Ports:
//   clk, rst            : clock and asynchronous active-high reset
//   in_valid, in_ready  : input handshake for operands a, b, c, d, mode
//   flush               : discard everything in flight at the next edge
//   out_valid, out_ready: output handshake for f and ovf
module arith_pipe
  import arith_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned MODE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  d,
  input  logic [MODE_W-1:0] mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  f,
  output logic              ovf
);

  localparam int unsigned S1W = 3 * WIDTH + MODE_W;
  localparam int unsigned S2W = 2 * WIDTH + MODE_W;
  localparam int unsigned S3W = WIDTH + 1;

  // A blocked output freezes every stage, so the whole pipe shares one hold.
  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall && !flush;

  // Stage 1
  logic [WIDTH-1:0]  y1, y2;
  logic [S1W-1:0]    s1_in, s1_q;
  logic              s1_valid;
  logic [WIDTH-1:0]  s1_y1, s1_y2, s1_d;
  logic [MODE_W-1:0] s1_mode;

  assign y1    = a + b;
  assign y2    = c - d;
  assign s1_in = {y1, y2, d, mode};

  pipe_stage #(.DataW(S1W)) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall),
    .clear    (flush),
    .in_valid (in_valid && in_ready),
    .in_data  (s1_in),
    .out_valid(s1_valid),
    .out_data (s1_q)
  );

  assign {s1_y1, s1_y2, s1_d, s1_mode} = s1_q;

  // Stage 2
  logic [WIDTH-1:0]  y3;
  logic [S2W-1:0]    s2_in, s2_q;
  logic              s2_valid;
  logic [WIDTH-1:0]  s2_y3, s2_d;
  logic [MODE_W-1:0] s2_mode;

  assign y3    = s1_y1 + s1_y2;
  assign s2_in = {y3, s1_d, s1_mode};

  pipe_stage #(.DataW(S2W)) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall),
    .clear    (flush),
    .in_valid (s1_valid),
    .in_data  (s2_in),
    .out_valid(s2_valid),
    .out_data (s2_q)
  );

  assign {s2_y3, s2_d, s2_mode} = s2_q;

  // Stage 3: full-width product so overflow can be detected
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   s3_f;
  logic               s3_ovf;
  logic [S3W-1:0]     s3_q;

  assign prod = {{WIDTH{1'b0}}, s2_y3} * {{WIDTH{1'b0}}, s2_d};

  always_comb begin
    s3_f   = prod[WIDTH-1:0];
    s3_ovf = |prod[2*WIDTH-1:WIDTH];
    if (s2_mode == MODE_W'(MODE_SUM)) begin
      s3_f   = s2_y3;
      s3_ovf = 1'b0;
    end
  end

  pipe_stage #(.DataW(S3W)) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .hold     (stall),
    .clear    (flush),
    .in_valid (s2_valid),
    .in_data  ({s3_ovf, s3_f}),
    .out_valid(out_valid),
    .out_data (s3_q)
  );

  assign {ovf, f} = s3_q;

endmodule

// File: tb/tb_arith_pipe.sv
// Self-checking bench for arith_pipe (WIDTH=8, MODE_W=1). A negedge monitor
// keeps a scoreboard of accepted transactions and checks every delivered
// result and the in_ready handshake; each test task adds inline checks.
module tb_arith_pipe;

  localparam int W  = 8;
  localparam int MW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a, b, c, d;
  logic [MW-1:0] mode;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          ovf;

  arith_pipe #(.WIDTH(W), .MODE_W(MW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .mode     (mode),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .f        (f),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] f;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  bit   exp_rdy;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference: plain integer arithmetic, wrapped to 8 bits where required.
  function automatic exp_t model(input logic [W-1:0] ia, ib, ic, id, input logic [MW-1:0] im);
    exp_t r;
    int   s;
    int   y3;
    int   p;
    s  = int'(ia) + int'(ib) + int'(ic) - int'(id);
    y3 = s & 255;
    if (im == 1'b1) begin
      r.f   = y3[W-1:0];
      r.ovf = 1'b0;
    end else begin
      p     = y3 * int'(id);
      r.f   = p[W-1:0];
      r.ovf = (p > 255);
    end
    return r;
  endfunction

  // Inputs change at posedge+1, so the negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      exp_rdy = !flush && !(out_valid && !out_ready);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++;
        $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL spurious_out: got out_valid=1 f=%0d want no result at %0t", f, $time);
        end else begin
          got = sb.pop_front();
          if (f !== got.f || ovf !== got.ovf) begin
            tests_failed++;
            $display("FAIL sb_result: got f=%0d ovf=%b want f=%0d ovf=%b at %0t",
                     f, ovf, got.f, got.ovf, $time);
          end
        end
      end
      if (flush) sb.delete();
      else if (in_valid && exp_rdy) sb.push_back(model(a, b, c, d, mode));
    end
  end

  task automatic put(input int v[5]);
    in_valid = 1'b1;
    a    = v[0][W-1:0];
    b    = v[1][W-1:0];
    c    = v[2][W-1:0];
    d    = v[3][W-1:0];
    mode = v[4][MW-1:0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int vec[4][5] = '{'{10, 5, 20, 3, 0}, '{8, 12, 6, 2, 0}, '{15, 7, 10, 4, 0}, '{1, 2, 3, 1, 0}};
  int vexp[4]   = '{96, 48, 112, 5};

  task automatic test_reset();
    tests_run++;
    if (out_valid !== 1'b0 || f !== 8'd0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b f=%0d ovf=%b want 0 0 0", out_valid, f, ovf);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_mulsum();
    int n;
    put(vec[0]);
    step();
    in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL latency: got %0d want 3", n);
    end
    tests_run++;
    if (f !== 8'd96 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL mulsum: got f=%0d ovf=%b want f=96 ovf=0", f, ovf);
    end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_out: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] vseq;
    int         fq[$];
    for (int i = 0; i < 10; i++) begin
      if (i < 4) put(vec[i]);
      else in_valid = 1'b0;
      step();
      vseq[i] = out_valid;
      if (out_valid === 1'b1) fq.push_back(int'(f));
    end
    tests_run++;
    if (vseq !== 10'b0000111100) begin
      tests_failed++;
      $display("FAIL b2b_valid_seq: got %b want 0000111100", vseq);
    end
    tests_run++;
    if (fq.size() != 4) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d want 4", fq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (fq[i] != vexp[i]) begin
          tests_failed++;
          $display("FAIL b2b_f%0d: got %0d want %0d", i, fq[i], vexp[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int ov[3][5] = '{'{100, 100, 0, 10, 0}, '{0, 0, 0, 1, 0}, '{8, 12, 6, 2, 1}};
    int ef[3]    = '{108, 255, 24};
    int eo[3]    = '{1, 0, 0};
    int fq[$];
    int oq[$];
    for (int i = 0; i < 8; i++) begin
      if (i < 3) put(ov[i]);
      else in_valid = 1'b0;
      step();
      if (out_valid === 1'b1) begin
        fq.push_back(int'(f));
        oq.push_back(int'(ovf));
      end
    end
    tests_run++;
    if (fq.size() != 3) begin
      tests_failed++;
      $display("FAIL ovf_count: got %0d want 3", fq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (fq[i] != ef[i] || oq[i] != eo[i]) begin
          tests_failed++;
          $display("FAIL ovf_wrap%0d: got f=%0d ovf=%0d want f=%0d ovf=%0d",
                   i, fq[i], oq[i], ef[i], eo[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fq[$];
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(vec[i]);
      step();
    end
    put(vec[3]);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || f !== 8'd96) begin
        tests_failed++;
        $display("FAIL stall%0d: got rdy=%b v=%b f=%0d want rdy=0 v=1 f=96",
                 k, in_ready, out_valid, f);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: got %b want 1", in_ready);
    end
    for (int j = 0; j < 8; j++) begin
      if (out_valid === 1'b1) fq.push_back(int'(f));
      step();
      if (j == 0) in_valid = 1'b0;
    end
    tests_run++;
    if (fq.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d want 4", fq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (fq[i] != vexp[i]) begin
          tests_failed++;
          $display("FAIL bp_order%0d: got %0d want %0d", i, fq[i], vexp[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    int cnt;
    put(vec[0]);
    step();
    put(vec[1]);
    step();
    put(vec[2]);
    flush = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) cnt++;
      step();
    end
    tests_run++;
    if (cnt != 0) begin
      tests_failed++;
      $display("FAIL flush_drop: got %0d outputs want 0", cnt);
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    for (int i = 0; i < 3; i++) begin
      put(vec[i]);
      step();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || f !== 8'd0 || ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_rst: got v=%b f=%0d ovf=%b want 0 0 0", out_valid, f, ovf);
    end
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_rst_ready: got %b want 1", in_ready);
    end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid !== 1'b0) cnt++;
      step();
    end
    tests_run++;
    if (cnt != 0) begin
      tests_failed++;
      $display("FAIL rst_drop: got %0d outputs want 0", cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    c         = '0;
    d         = '0;
    mode      = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    test_reset();
    step();
    test_mulsum();
    step();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_flush();
    test_async_reset();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
